mem_stage: RTL and testbench

//  Memory-access pipeline stage between the execute stage and the write-back stage.

---
 rtl/mem_stage.sv | 98 +++++++++
 tb/tb_mem_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Purpose : memory-access pipeline stage; latches the execute bus and merges SRAM load data into the result.
// Latency : one cycle execute -> write-back when write-back accepts; SRAM read data is taken the cycle after accept.
// Backpres: ms_allowin drops while holding a valid instruction and write-back stalls; load data is captured so the result stays stable.
//
// Ports:
//   clk, resetn                    clock and asynchronous active-low reset
//   es_to_ms_valid/es_to_ms_bus    execute offer {res_from_mem, gr_we, dest, alu_result, pc}
//   ms_allowin                     this stage can take a new instruction
//   ws_allowin                     write-back can take an instruction
//   ms_to_ws_valid/ms_to_ws_bus    write-back offer {gr_we, dest, final_result, pc}
//   data_sram_rdata                synchronous SRAM read data (valid the cycle after the address cycle)
//   ms_write_reg/ms_reg_dest       hazard info for decode
//   ms_fwd_ok/ms_to_ds_bus         forwarding info for decode
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 71,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_write_reg,
    output logic [4:0]                 ms_reg_dest,
    output logic                       ms_fwd_ok,
    output logic [31:0]                ms_to_ds_bus
);

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_bus_t;

    es_bus_t     r_es_bus;
    logic        r_ms_valid;
    logic        r_first;       // high only in the cycle whose SRAM read data belongs to us
    logic        r_buf_valid;
    logic [31:0] r_rdata_buf;

    logic        w_ms_ready_go;
    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;

    assign w_ms_ready_go  = 1'b1;
    assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
    assign w_accept       = ms_allowin && es_to_ms_valid;

    // Live read data is only present in the first cycle; if write-back is
    // stalling then, keep a copy so the result survives the stall.
    assign w_capture = r_ms_valid && r_es_bus.res_from_mem && r_first && !ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid  <= 1'b0;
            r_es_bus    <= '0;
            r_first     <= 1'b0;
            r_buf_valid <= 1'b0;
            r_rdata_buf <= 32'h0;
        end else begin
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_accept) begin
                // A new arrival discards whatever the previous instruction buffered.
                r_es_bus    <= es_to_ms_bus;
                r_first     <= 1'b1;
                r_buf_valid <= 1'b0;
            end else begin
                r_first <= 1'b0;
                if (w_capture) begin
                    r_rdata_buf <= data_sram_rdata;
                    r_buf_valid <= 1'b1;
                end
            end
        end
    end

    assign w_load_data    = r_buf_valid ? r_rdata_buf : data_sram_rdata;
    assign w_final_result = r_es_bus.res_from_mem ? w_load_data : r_es_bus.alu_result;

    assign ms_to_ws_bus = {r_es_bus.gr_we, r_es_bus.dest, w_final_result, r_es_bus.pc};

    assign ms_write_reg = r_ms_valid && r_es_bus.gr_we;
    assign ms_reg_dest  = r_es_bus.dest;
    assign ms_to_ds_bus = w_final_result;
    assign ms_fwd_ok    = r_ms_valid && (!r_es_bus.res_from_mem || r_first || r_buf_valid);

endmodule

// File: tb/tb_mem_stage.sv
// Purpose : self-checking bench for mem_stage: directed scenarios plus randomized traffic against a reference model.
// Latency : one instruction per clock when write-back accepts.
// Backpres: write-back stalls are driven randomly and in directed stall scenarios.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic [70:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_write_reg;
    logic [4:0]  ms_reg_dest;
    logic        ms_fwd_ok;
    logic [31:0] ms_to_ds_bus;

    int checks   = 0;
    int failures = 0;

    // Reference model: the instruction currently held and the value its load returned.
    bit          m_valid;
    bit          m_first;
    bit          m_load;
    bit          m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_alu;
    logic [31:0] m_pc;
    logic [31:0] m_ldval;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_allowin      (ms_allowin),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_write_reg    (ms_write_reg),
        .ms_reg_dest     (ms_reg_dest),
        .ms_fwd_ok       (ms_fwd_ok),
        .ms_to_ds_bus    (ms_to_ds_bus)
    );

    function automatic logic [70:0] mk_bus(input bit ld, input bit we, input logic [4:0] d,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {ld, we, d, alu, pc};
    endfunction

    task automatic drive(input bit v, input logic [70:0] b, input bit wa, input logic [31:0] rd);
        es_to_ms_valid  = v;
        es_to_ms_bus    = b;
        ws_allowin      = wa;
        data_sram_rdata = rd;
    endtask

    task automatic model_reset();
        m_valid = 0; m_first = 0; m_load = 0; m_we = 0;
        m_dest = '0; m_alu = '0; m_pc = '0; m_ldval = '0;
    endtask

    // A load's value is whatever the SRAM returned in the cycle right after it
    // arrived; before that cycle ends the live data is that value.
    function automatic logic [31:0] exp_result();
        if (!m_load) return m_alu;
        return m_first ? data_sram_rdata : m_ldval;
    endfunction

    // Advance one clock with the inputs currently driven, updating the model.
    task automatic tick();
        bit allow;
        bit acc;
        allow = !m_valid || ws_allowin;
        acc   = allow && es_to_ms_valid;
        if (m_valid && m_first && m_load) m_ldval = data_sram_rdata;
        if (acc) {m_load, m_we, m_dest, m_alu, m_pc} = es_to_ms_bus;
        if (allow) m_valid = es_to_ms_valid;
        m_first = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(0, '0, 0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ms_to_ws_valid); end
        checks++; if (ms_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%0b exp=1", ms_allowin); end
        checks++; if (ms_write_reg !== 1'b0) begin failures++; $display("FAIL reset_write_reg got=%0b exp=0", ms_write_reg); end
        checks++; if (ms_fwd_ok !== 1'b0) begin failures++; $display("FAIL reset_fwd_ok got=%0b exp=0", ms_fwd_ok); end
        checks++; if (ms_reg_dest !== 5'd0) begin failures++; $display("FAIL reset_reg_dest got=%0d exp=0", ms_reg_dest); end
        checks++; if (ms_to_ds_bus !== 32'h0) begin failures++; $display("FAIL reset_to_ds got=%h exp=0", ms_to_ds_bus); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_alu_pass();
        drive(1, mk_bus(0, 1, 5'd3, 32'h1234_5678, 32'hBFC0_0000), 1, $urandom);
        #1; tick();
        drive(0, '0, 1, $urandom);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%0b exp=1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_bus !== {1'b1, 5'd3, 32'h1234_5678, 32'hBFC0_0000})
            begin failures++; $display("FAIL alu_bus got=%h exp=%h", ms_to_ws_bus, {1'b1, 5'd3, 32'h1234_5678, 32'hBFC0_0000}); end
        checks++; if (ms_write_reg !== 1'b1 || ms_reg_dest !== 5'd3)
            begin failures++; $display("FAIL alu_hazard got=%0b/%0d exp=1/3", ms_write_reg, ms_reg_dest); end
        tick();
    endtask

    task automatic test_load_no_stall();
        drive(1, mk_bus(1, 1, 5'd7, 32'h0000_1000, 32'hBFC0_0010), 1, 32'h0);
        #1; tick();
        drive(0, '0, 1, 32'hDEAD_BEEF);
        #1;
        checks++; if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_result got=%h exp=deadbeef", ms_to_ws_bus[63:32]); end
        checks++; if (ms_fwd_ok !== 1'b1 || ms_to_ds_bus !== 32'hDEAD_BEEF)
            begin failures++; $display("FAIL load_fwd got=%0b/%h exp=1/deadbeef", ms_fwd_ok, ms_to_ds_bus); end
        tick();
    endtask

    task automatic test_load_stall();
        drive(1, mk_bus(1, 1, 5'd9, 32'h0000_2000, 32'hBFC0_0020), 1, 32'h0);
        #1; tick();
        for (int c = 0; c < 4; c++) begin
            // Stall for three cycles, release on the fourth; data is live only in the first.
            drive(0, '0, (c == 3), (c == 0) ? 32'hDEAD_BEEF : 32'h0);
            #1;
            checks++; if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF || ms_to_ws_valid !== 1'b1)
                begin failures++; $display("FAIL stall_result c=%0d got=%h/%0b exp=deadbeef/1", c, ms_to_ws_bus[63:32], ms_to_ws_valid); end
            checks++; if (ms_allowin !== (c == 3))
                begin failures++; $display("FAIL stall_allowin c=%0d got=%0b exp=%0b", c, ms_allowin, (c == 3)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        // Stalled load fills the buffer, then a second load replaces it on the leave edge.
        drive(1, mk_bus(1, 1, 5'd1, 32'h0, 32'h100), 1, 32'h0);
        #1; tick();
        drive(0, '0, 0, 32'h1111_1111);
        #1; tick();
        drive(1, mk_bus(1, 1, 5'd2, 32'h0, 32'h104), 1, 32'h2222_2222);
        #1;
        checks++; if (ms_to_ws_bus[63:32] !== 32'h1111_1111) begin failures++; $display("FAIL b2b_buffered got=%h exp=11111111", ms_to_ws_bus[63:32]); end
        tick();
        drive(1, mk_bus(0, 1, 5'd4, 32'h0000_0007, 32'h108), 1, 32'hDEAD_BEEF);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF)
            begin failures++; $display("FAIL b2b_load got=%0b/%h exp=1/deadbeef", ms_to_ws_valid, ms_to_ws_bus[63:32]); end
        tick();
        drive(0, '0, 1, 32'h3333_3333);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== 32'h0000_0007)
            begin failures++; $display("FAIL b2b_alu got=%0b/%h exp=1/00000007", ms_to_ws_valid, ms_to_ws_bus[63:32]); end
        tick();
    endtask

    task automatic test_bubble();
        drive(1, mk_bus(0, 1, 5'd9, 32'hCAFE_0001, 32'h200), 1, 32'h0);
        #1; tick();
        drive(0, '0, 1, 32'h0);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL bubble_pre got=%0b exp=1", ms_to_ws_valid); end
        tick();
        drive(0, mk_bus(0, 1, 5'd30, 32'h5, 32'h5), 1, 32'h0);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_write_reg !== 1'b0 || ms_allowin !== 1'b1)
            begin failures++; $display("FAIL bubble_flags got=%0b/%0b/%0b exp=0/0/1", ms_to_ws_valid, ms_write_reg, ms_allowin); end
        checks++; if (ms_reg_dest !== 5'd9 || ms_to_ds_bus !== 32'hCAFE_0001)
            begin failures++; $display("FAIL bubble_hold got=%0d/%h exp=9/cafe0001", ms_reg_dest, ms_to_ds_bus); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive(1, mk_bus(1, 1, 5'd5, 32'h0, 32'h300), 1, 32'h0);
        #1; tick();
        drive(0, '0, 0, 32'h5555_AAAA);
        #1; tick();
        drive(0, '0, 0, 32'h0);
        #3;
        resetn = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_write_reg !== 1'b0)
            begin failures++; $display("FAIL async_reset got=%0b/%0b/%0b exp=0/1/0", ms_to_ws_valid, ms_allowin, ms_write_reg); end
        checks++; if (ms_fwd_ok !== 1'b0 || ms_to_ds_bus !== 32'h0)
            begin failures++; $display("FAIL async_reset_fwd got=%0b/%h exp=0/0", ms_fwd_ok, ms_to_ds_bus); end
        @(negedge clk);
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 9) < 7),
                  mk_bus($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom), $urandom, $urandom),
                  ($urandom_range(0, 2) != 0), $urandom);
            #1;
            e = exp_result();
            checks++; if (ms_to_ws_valid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, ms_to_ws_valid, m_valid); end
            checks++; if (ms_allowin !== (!m_valid || ws_allowin)) begin failures++; $display("FAIL rnd_allowin n=%0d got=%0b exp=%0b", n, ms_allowin, (!m_valid || ws_allowin)); end
            checks++; if (ms_write_reg !== (m_valid && m_we)) begin failures++; $display("FAIL rnd_write_reg n=%0d got=%0b exp=%0b", n, ms_write_reg, (m_valid && m_we)); end
            checks++; if (ms_reg_dest !== m_dest) begin failures++; $display("FAIL rnd_dest n=%0d got=%0d exp=%0d", n, ms_reg_dest, m_dest); end
            if (m_valid) begin
                checks++; if (ms_to_ws_bus !== {m_we, m_dest, e, m_pc})
                    begin failures++; $display("FAIL rnd_bus n=%0d got=%h exp=%h", n, ms_to_ws_bus, {m_we, m_dest, e, m_pc}); end
                checks++; if (ms_fwd_ok !== 1'b1 || ms_to_ds_bus !== e)
                    begin failures++; $display("FAIL rnd_fwd n=%0d got=%0b/%h exp=1/%h", n, ms_fwd_ok, ms_to_ds_bus, e); end
            end else begin
                checks++; if (ms_fwd_ok !== 1'b0) begin failures++; $display("FAIL rnd_fwd_idle n=%0d got=%0b exp=0", n, ms_fwd_ok); end
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_pass();
        test_load_no_stall();
        test_load_stall();
        test_back_to_back();
        test_bubble();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
